// File: rtl/aurora_rx_frame_filter_if.sv
// aurora_rx_frame_filter_if: 64-bit stream bundle with byte keep, last and valid/ready handshake
interface aurora_rx_frame_filter_if;
  logic [63:0] tdata;
  logic [7:0] tkeep;
  logic tlast;
  logic tvalid;
  logic tready;
  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/aurora_rx_frame_filter.sv
// aurora_rx_frame_filter: store-and-forward RX frame buffer that only releases CRC-passed frames
module aurora_rx_frame_filter #(
  parameter int ADDR_WIDTH = 9,
  parameter int CRC_TIMEOUT = 16,
  parameter int COUNT_WIDTH = 16
) (
  input logic auMGTclkOut,
  input logic resetOut,
  aurora_rx_frame_filter_if.slave s,
  input logic axiCrcValid,
  input logic axiCrcPass,
  aurora_rx_frame_filter_if.master m,
  output logic [COUNT_WIDTH-1:0] goodCount,
  output logic [COUNT_WIDTH-1:0] crcErrCount,
  output logic [COUNT_WIDTH-1:0] ovfCount,
  output logic rxBusy
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int TW = $clog2(CRC_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, FRAME, DROP, WAIT_CRC} state_t;
  state_t state;
  logic [72:0] mem [DEPTH];
  logic [72:0] out_beat;
  logic out_valid;
  logic [ADDR_WIDTH:0] wr_ptr, wr_commit, rd_ptr, start, base, used;
  logic [TW-1:0] timer;
  logic wait_st, wait_pass, wait_drop, full, accept, we, eof_crc;
  logic good_inc, err_inc, ovf_inc, avail, load;
  // a pending frame in WAIT_CRC resolves before any new beat; start is where the next frame begins
  assign wait_st = state == WAIT_CRC;
  assign wait_pass = wait_st && axiCrcValid && axiCrcPass;
  assign wait_drop = wait_st && !wait_pass && (axiCrcValid || timer == '0 || s.tvalid);
  assign start = wait_pass ? wr_ptr : wr_commit;
  assign base = state == FRAME ? wr_ptr : start;
  assign used = base - rd_ptr;
  assign full = used == (ADDR_WIDTH + 1)'(DEPTH);
  assign accept = s.tvalid && state != DROP;
  assign we = accept && !full;
  assign eof_crc = we && s.tlast && axiCrcValid && !wait_st;
  assign good_inc = wait_pass || (eof_crc && axiCrcPass);
  assign err_inc = wait_drop || (eof_crc && !axiCrcPass);
  assign ovf_inc = accept && full;
  // write FSM: buffer beats, then commit or rewind the frame once its CRC status is known
  always_ff @(posedge auMGTclkOut or posedge resetOut)
    if (resetOut) begin
      state <= IDLE;
      wr_ptr <= '0;
      wr_commit <= '0;
      timer <= '0;
      goodCount <= '0;
      crcErrCount <= '0;
      ovfCount <= '0;
    end else begin
      goodCount <= goodCount + COUNT_WIDTH'(good_inc);
      crcErrCount <= crcErrCount + COUNT_WIDTH'(err_inc);
      ovfCount <= ovfCount + COUNT_WIDTH'(ovf_inc);
      if (ovf_inc) begin
        wr_ptr <= start;
        wr_commit <= start;
        state <= s.tlast ? IDLE : DROP;
      end else if (we) begin
        wr_ptr <= eof_crc && !axiCrcPass ? start : base + 1'b1;
        wr_commit <= eof_crc && axiCrcPass ? base + 1'b1 : start;
        state <= eof_crc ? IDLE : s.tlast ? WAIT_CRC : FRAME;
        timer <= TW'(CRC_TIMEOUT - 1);
      end else if (state == DROP) begin
        if (s.tvalid && s.tlast) state <= IDLE;
      end else if (wait_st) begin
        wr_commit <= start;
        if (wait_drop) wr_ptr <= wr_commit;
        state <= wait_pass || wait_drop ? IDLE : WAIT_CRC;
        timer <= timer - 1'b1;
      end
    end
  // buffer write at the current frame position
  always_ff @(posedge auMGTclkOut)
    if (we) mem[base[ADDR_WIDTH-1:0]] <= {s.tlast, s.tkeep, s.tdata};
  assign avail = rd_ptr != wr_commit;
  assign load = avail && (!out_valid || m.tready);
  // output register refills from committed beats whenever empty or being consumed
  always_ff @(posedge auMGTclkOut or posedge resetOut)
    if (resetOut) begin
      rd_ptr <= '0;
      out_valid <= 1'b0;
      out_beat <= '0;
    end else if (load) begin
      out_beat <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      out_valid <= 1'b1;
      rd_ptr <= rd_ptr + 1'b1;
    end else if (m.tready) begin
      out_valid <= 1'b0;
    end
  assign {m.tlast, m.tkeep, m.tdata} = out_beat;
  assign m.tvalid = out_valid;
  assign s.tready = 1'b1;
  assign rxBusy = state != IDLE;
endmodule

// File: doc/aurora_rx_frame_filter.md
Name: aurora_rx_frame_filter

Overview:
Store-and-forward filter on the 64-bit Aurora 64B66B receive stream in the auMGTclkOut domain, placed between the MGT core RX user interface and the 64-to-32 downconversion.
- Buffers each incoming frame.
- Releases the frame downstream only if the core reports CRC pass.
- Discards frames with a CRC failure, a missing CRC status, or a buffer overflow.
- Keeps per-cause frame counters for the CSR path.
- The upstream stream has no backpressure; the downstream side is a full tvalid/tready AXI stream.

Parameters:
ADDR_WIDTH, 9, log2 of buffer depth in 64-bit beats (DEPTH = 2^ADDR_WIDTH).
CRC_TIMEOUT, 16, cycles after tlast to wait for axiCrcValid before declaring the CRC status missing.
COUNT_WIDTH, 16, width of each frame counter.

Ports:
auMGTclkOut  in  1  clock; all logic is in this domain.
resetOut  in  1  reset: asynchronous assertion, active-high; clock auMGTclkOut. Deassertion is synchronous to auMGTclkOut.
sTdata  in  64  RX data from the MGT core.
sTkeep  in  8  RX byte enables; stored and forwarded unchanged.
sTlast  in  1  end of frame.
sTvalid  in  1  beat valid; there is no tready.
axiCrcValid  in  1  single-cycle CRC status strobe.
axiCrcPass  in  1  CRC result, qualified by axiCrcValid.
mTdata  out  64  filtered data.
mTkeep  out  8  filtered byte enables.
mTlast  out  1  end of frame.
mTvalid  out  1  output valid.
mTready  in  1  downstream ready.
goodCount  out  COUNT_WIDTH  frames committed.
crcErrCount  out  COUNT_WIDTH  frames dropped for CRC fail or missing CRC status.
ovfCount  out  COUNT_WIDTH  frames dropped for overflow.
rxBusy  out  1  high while the write FSM is not IDLE.

Behaviour:
- Reset: all pointers and counters are 0, the FSM is IDLE, and mTvalid, mTlast and rxBusy are 0. mTdata and mTkeep are 0. Reset mid-frame discards everything held in the buffer, including committed frames not yet read.
- Storage: DEPTH entries of {last, keep[7:0], data[63:0]}.
- Pointers: wrPtr, wrCommit and rdPtr are each ADDR_WIDTH+1 bits and wrap modulo 2^(ADDR_WIDTH+1).
  - full = (wrPtr - rdPtr == DEPTH).
  - Data is available when rdPtr != wrCommit.
- Write FSM states: IDLE, FRAME, DROP, WAIT_CRC.
- IDLE:
  - sTvalid with full: go to DROP (or stay IDLE if sTlast), and increment ovfCount.
  - sTvalid otherwise: write the beat and go to FRAME. If sTlast, handle it as the end of frame below.
- FRAME:
  - Each sTvalid beat is written and wrPtr increments.
  - A beat arriving while full: wrPtr <= wrCommit, increment ovfCount, go to DROP (or IDLE if that beat has sTlast).
- End of frame (the tlast beat written):
  - If axiCrcValid is high in the same cycle, resolve immediately: pass commits (wrCommit <= wrPtr+1, goodCount+1); fail rewinds (wrPtr <= wrCommit, crcErrCount+1). Then go to IDLE.
  - Otherwise go to WAIT_CRC with the timer loaded to CRC_TIMEOUT.
- WAIT_CRC:
  - axiCrcValid: resolve as above, go to IDLE.
  - Timer reaches 0: rewind, crcErrCount+1, go to IDLE.
  - sTvalid before CRC arrives: rewind the pending frame, crcErrCount+1, and treat the beat as a new frame from IDLE in the same cycle.
- DROP: beats are ignored. On a beat with sTlast, go to IDLE. No CRC wait follows.
- axiCrcValid in IDLE, FRAME or DROP is ignored.
- Read side:
  - First-word-fall-through with an output register.
  - The first beat of a frame is presented on mTvalid no later than 2 cycles after its commit cycle.
  - The beat transfers when mTvalid && mTready.
  - Output fields are held stable while mTvalid && !mTready.
  - Back-to-back beats sustain 1 beat/cycle while mTready=1.
  - Committed beats are never lost or reordered. Frames are emitted whole and in arrival order.
- Counters: each increments by 1 per event and wraps at 2^COUNT_WIDTH.
- A frame longer than DEPTH beats is always dropped, since full is reached first.

Test Plan:
1. Three 4-beat frames, each with CRC pass on the tlast cycle, mTready=1 -> 12 beats out in order; mTlast on beats 4, 8 and 12; goodCount=3, crcErrCount=0.
2. A 5-beat frame, then axiCrcValid=1, axiCrcPass=0 three cycles after tlast -> no output; crcErrCount=1; a following good 2-beat frame is output intact.
3. A 3-beat frame with no CRC strobe -> dropped CRC_TIMEOUT=16 cycles after tlast; crcErrCount=1; rxBusy=0 afterwards.
4. ADDR_WIDTH=4, mTready=0, a good 10-beat frame, then a 10-beat frame -> the second frame is dropped; ovfCount=1. Release mTready -> exactly the first 10 beats are output.
5. mTready toggled 1/0 each cycle during a 6-beat frame -> mTdata stable while stalled; 6 beats transferred with no duplicates.
6. resetOut pulsed mid-way through a frame, with one committed frame unread -> mTvalid=0 and counters=0 in the cycle after assertion. A subsequent good frame is output normally.
